// File: rtl/pool_window_gen.sv
// pool_window_gen: producer side of the 2x2 max-pool datapath.
// Buffers each even row of a raster-order pixel stream. On every odd-column
// pixel of the following odd row it emits one non-overlapping 2x2 window,
// packed in the lane order the max-pool unit consumes:
//   [D-1:0]=p(r,c)  [2D-1:D]=p(r,c+1)  [3D-1:2D]=p(r+1,c)  [4D-1:3D]=p(r+1,c+1)
// Optional feature: define POOL_WIN_CNT_EN to add a saturating 16-bit count
// of accepted windows (win_count).
module pool_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] out_window,
  output logic                frame_done
`ifdef POOL_WIN_CNT_EN
  ,
  output logic [15:0]         win_count
`endif
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // TOP: even row, filling the line buffer. BOT: odd row, emitting windows.
  typedef enum logic {
    ST_TOP = 1'b0,
    ST_BOT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic                  out_valid_q, out_valid_d;
  logic [4*DATA_W-1:0]   out_window_q, out_window_d;
  logic                  last_q, last_d;     // held window is the frame's last one
  logic                  frame_done_q, frame_done_d;
  logic [DATA_W-1:0]     linebuf_q [IMG_W];
  logic                  lb_we;
  logic                  in_xfer;
  logic                  out_accept;
  logic                  col_end;

`ifdef POOL_WIN_CNT_EN
  logic [15:0]           win_count_q, win_count_d;
`endif

  assign in_ready   = ~out_valid_q | out_ready;
  assign in_xfer    = in_valid & in_ready;
  assign out_accept = out_valid_q & out_ready;
  assign col_end    = (col_q == COL_LAST);

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign frame_done = frame_done_q;

  // Next-state logic: raster counters, row-parity FSM, output register refill.
  // NOTE: every signal gets its default before any branch, so no path leaves
  // a combinational output unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    last_d       = last_q;
    frame_done_d = out_accept & last_q;
    lb_we        = 1'b0;

    // An accepted window empties the register unless a new one refills it below.
    if (out_accept) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      // Frame restart wins over all traffic; any input beat this cycle is dropped.
      state_d      = ST_TOP;
      col_d        = '0;
      row_d        = '0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end else if (in_xfer) begin
      if (col_end) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      unique case (state_q)
        ST_TOP: begin
          lb_we = 1'b1;
          if (col_end) state_d = ST_BOT;
        end
        ST_BOT: begin
          if (!col_q[0]) begin
            hold_d = in_data;
          end else begin
            out_window_d = {in_data, hold_q, linebuf_q[col_q], linebuf_q[col_q - COL_W'(1)]};
            out_valid_d  = 1'b1;
            last_d       = (row_q == ROW_LAST) && col_end;
          end
          if (col_end) state_d = ST_TOP;
        end
        default: state_d = ST_TOP;
      endcase
    end
  end

  // Control and output registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_TOP;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer write port; reads above are asynchronous.
  // NOTE: the line buffer has no reset: every entry is rewritten in TOP before
  // BOT reads it, and leaving it unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[col_q] <= in_data;
    end
  end

`ifdef POOL_WIN_CNT_EN
  // Saturating count of accepted windows; survives frame boundaries.
  always_comb begin
    win_count_d = win_count_q;
    if (clear) begin
      win_count_d = '0;
    end else if (out_accept && (win_count_q != 16'hFFFF)) begin
      win_count_d = win_count_q + 16'd1;
    end
  end

  // Window counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) win_count_q <= '0;
    else          win_count_q <= win_count_d;
  end

  assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: directed bench for pool_window_gen.
// Small instance (4x2 image) covers the cycle-exact stream, back-pressure,
// back-to-back frames, clear and async reset. Large instance (16x16) runs
// three random frames under random back-pressure against a reference model.
// win_count is checked when POOL_WIN_CNT_EN is defined.
module tb_pool_window_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_window;
  logic        frame_done;

  logic        clear_l;
  logic        in_valid_l;
  logic        in_ready_l;
  logic [7:0]  in_data_l;
  logic        out_valid_l;
  logic        out_ready_l;
  logic [31:0] out_window_l;
  logic        frame_done_l;
  logic        rand_en;

`ifdef POOL_WIN_CNT_EN
  logic [15:0] win_count;
  logic [15:0] win_count_l;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pool_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) dut_s (
    .clk        (clk),
    .reset_n    (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .frame_done (frame_done)
`ifdef POOL_WIN_CNT_EN
    ,
    .win_count  (win_count)
`endif
  );

  pool_window_gen #(.DATA_W(8), .IMG_W(16), .IMG_H(16)) dut_l (
    .clk        (clk),
    .reset_n    (rst_n),
    .clear      (clear_l),
    .in_valid   (in_valid_l),
    .in_ready   (in_ready_l),
    .in_data    (in_data_l),
    .out_valid  (out_valid_l),
    .out_ready  (out_ready_l),
    .out_window (out_window_l),
    .frame_done (frame_done_l)
`ifdef POOL_WIN_CNT_EN
    ,
    .win_count  (win_count_l)
`endif
  );

  // Accepted windows and frame_done pulses, recorded at the negative edge.
  logic [31:0] win_q[$];
  logic [31:0] win_q_l[$];
  int          fd_cnt   = 0;
  int          fd_cnt_l = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready)     win_q.push_back(out_window);
      if (frame_done)                 fd_cnt++;
      if (out_valid_l && out_ready_l) win_q_l.push_back(out_window_l);
      if (frame_done_l)               fd_cnt_l++;
    end
  end

  // Random back-pressure for the large instance.
  initial begin
    out_ready_l = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready_l = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int idx);
    return (idx < win_q.size()) ? win_q[idx] : 32'hFFFF_FFFF;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: in_ready got 0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_l(input logic [7:0] d);
    int n;
    n          = 0;
    in_valid_l = 1'b1;
    in_data_l  = d;
    @(negedge clk);
    while (!in_ready_l && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_l_timeout: in_ready got 0 for 200 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid_l = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_win;
    logic        e_fd;
  } vec_t;

  vec_t        vecs[11];
  logic [7:0]  pix[768];
  logic [31:0] exp_l[$];

  initial begin
    // Cycle-exact stream 1..8 with out_ready=1 (row 0 = 1..4, row 1 = 5..8).
    vecs[0]  = '{1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b1, 8'd5, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 8'd6, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 32'h06050201, 1'b0};
    vecs[7]  = '{1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 32'h08070403, 1'b0};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};

    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    clear_l    = 1'b0;
    in_valid_l = 1'b0;
    in_data_l  = '0;
    rand_en    = 1'b0;

    // Reset state.
    #23;
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_out_window", out_window,      32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_in_ready",   32'(in_ready),   32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: table-driven cycle-by-cycle stream.
    for (int i = 0; i < 11; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("t1_in_ready[%0d]", i),   32'(in_ready),   32'(vecs[i].e_irdy));
      check($sformatf("t1_out_valid[%0d]", i),  32'(out_valid),  32'(vecs[i].e_ov));
      check($sformatf("t1_frame_done[%0d]", i), 32'(frame_done), 32'(vecs[i].e_fd));
      if (vecs[i].e_ov) check($sformatf("t1_window[%0d]", i), out_window, vecs[i].e_win);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Test 2: downstream stalls from the first window onward.
    win_q.delete();
    fd_cnt    = 0;
    out_ready = 1'b0;
    for (int p = 1; p <= 6; p++) push(8'(p));
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_stall_valid",  32'(out_valid), 32'h1);
      check("t2_stall_window", out_window,     32'h06050201);
      check("t2_stall_ready",  32'(in_ready),  32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(8'd7);
    push(8'd8);
    idle(4);
    check("t2_count", 32'(win_q.size()), 32'd2);
    check("t2_win0",  q_at(0),           32'h06050201);
    check("t2_win1",  q_at(1),           32'h08070403);
    check("t2_fd",    32'(fd_cnt),       32'd1);

    // Test 3: two frames back to back.
    win_q.delete();
    fd_cnt = 0;
    for (int p = 1; p <= 16; p++) push(8'(p));
    idle(4);
    check("t3_count", 32'(win_q.size()), 32'd4);
    check("t3_win2",  q_at(2),           32'h0E0D0A09);
    check("t3_win3",  q_at(3),           32'h100F0C0B);
    check("t3_fd",    32'(fd_cnt),       32'd2);

    // Test 4: clear mid-frame discards the partial frame and its own input beat.
    win_q.delete();
    fd_cnt = 0;
    for (int p = 1; p <= 5; p++) push(8'(p));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h63;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t4_clear_valid", 32'(out_valid), 32'h0);
    for (int p = 11; p <= 18; p++) push(8'(p));
    idle(4);
    check("t4_count", 32'(win_q.size()), 32'd2);
    check("t4_win0",  q_at(0),           32'h100F0C0B);
    check("t4_win1",  q_at(1),           32'h12110E0D);
    check("t4_fd",    32'(fd_cnt),       32'd1);
`ifdef POOL_WIN_CNT_EN
    check("t4_win_count", 32'(win_count), 32'd2);
`endif

    // Test 5: asynchronous reset while a window is held.
    out_ready = 1'b0;
    for (int p = 1; p <= 6; p++) push(8'(p));
    check("t5_pre_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid",  32'(out_valid), 32'h0);
    check("t5_rst_window", out_window,     32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    win_q.delete();
    fd_cnt = 0;
    for (int p = 1; p <= 8; p++) push(8'(p));
    idle(4);
    check("t5_count", 32'(win_q.size()), 32'd2);
    check("t5_win0",  q_at(0),           32'h06050201);
    check("t5_win1",  q_at(1),           32'h08070403);
    check("t5_fd",    32'(fd_cnt),       32'd1);

    // Test 6: 16x16, three random frames, random back-pressure.
    win_q_l.delete();
    fd_cnt_l = 0;
    for (int i = 0; i < 768; i++) pix[i] = 8'($urandom_range(0, 255));
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 16; r += 2)
        for (int c = 0; c < 16; c += 2)
          exp_l.push_back({pix[f*256 + (r+1)*16 + c+1], pix[f*256 + (r+1)*16 + c],
                           pix[f*256 + r*16 + c+1],     pix[f*256 + r*16 + c]});
    rand_en = 1'b1;
    for (int i = 0; i < 768; i++) push_l(pix[i]);
    rand_en = 1'b0;
    idle(10);
    check("t6_count", 32'(win_q_l.size()), 32'd192);
    for (int i = 0; i < 192; i++)
      check($sformatf("t6_win[%0d]", i),
            (i < win_q_l.size()) ? win_q_l[i] : ~exp_l[i], exp_l[i]);
    check("t6_fd", 32'(fd_cnt_l), 32'd3);
`ifdef POOL_WIN_CNT_EN
    check("t6_win_count", 32'(win_count_l), 32'd192);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
